// File: rtl/ascon_job_sequencer.sv
// ascon_job_sequencer: accepts one AEAD job, starts the core, streams input
// blocks into it, buffers each output block in a one-entry register, captures
// and checks the tag, and returns one response per job. A watchdog aborts a
// job whose core-side traffic stalls.
module ascon_job_sequencer #(
  parameter int SIZE_WIDTH  = 8,
  parameter int BLOCK_WIDTH = 128,
  parameter int TAG_WIDTH   = 128,
  parameter int KEY_WIDTH   = 128,
  parameter int NONCE_WIDTH = 128,
  parameter int WDOG_WIDTH  = 12
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cmd_valid_i,
  output logic                   cmd_ready_o,
  input  logic                   cmd_decrypt_i,
  input  logic [SIZE_WIDTH-1:0]  cmd_ad_size_i,
  input  logic [SIZE_WIDTH-1:0]  cmd_di_size_i,
  input  logic [KEY_WIDTH-1:0]   cmd_key_i,
  input  logic [NONCE_WIDTH-1:0] cmd_nonce_i,
  input  logic [TAG_WIDTH-1:0]   cmd_tag_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [BLOCK_WIDTH-1:0] in_data_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [BLOCK_WIDTH-1:0] out_data_o,
  output logic                   resp_valid_o,
  input  logic                   resp_ready_i,
  output logic [TAG_WIDTH-1:0]   resp_tag_o,
  output logic                   resp_tag_ok_o,
  output logic                   resp_err_o,
  output logic                   core_start_o,
  output logic                   core_decrypt_o,
  output logic [SIZE_WIDTH-1:0]  core_ad_size_o,
  output logic [SIZE_WIDTH-1:0]  core_di_size_o,
  output logic [KEY_WIDTH-1:0]   core_key_o,
  output logic [NONCE_WIDTH-1:0] core_nonce_o,
  output logic [BLOCK_WIDTH-1:0] core_data_o,
  output logic                   core_data_valid_o,
  input  logic                   core_idle_i,
  input  logic                   core_done_i,
  input  logic                   core_data_ready_i,
  input  logic [BLOCK_WIDTH-1:0] core_data_i,
  input  logic                   core_data_valid_i,
  input  logic [TAG_WIDTH-1:0]   core_tag_i,
  input  logic                   core_tag_valid_i
);

  typedef enum logic [2:0] {S_IDLE, S_START, S_RUN, S_DRAIN, S_RESP} state_t;

  state_t                 state, state_nx;
  logic                   dec_q;
  logic [SIZE_WIDTH-1:0]  ad_size_q, di_size_q;
  logic [KEY_WIDTH-1:0]   key_q;
  logic [NONCE_WIDTH-1:0] nonce_q;
  logic [TAG_WIDTH-1:0]   exp_tag_q, tag_q;
  logic                   tag_ok_q, err_q, tag_seen_q;
  logic                   out_valid_q;
  logic [BLOCK_WIDTH-1:0] out_data_q;
  logic [WDOG_WIDTH-1:0]  wdog_q;

  logic run, accept, fwd, consume, activity, wdog_full;

  assign run       = (state == S_RUN);
  assign accept    = cmd_valid_i && cmd_ready_o;
  // Holding input off while the output register is full means the core can
  // never emit a block the register has no room for.
  assign fwd       = run && in_valid_i && core_data_ready_i && !out_valid_q;
  assign consume   = out_valid_q && out_ready_i;
  assign activity  = fwd || core_data_valid_i || core_tag_valid_i || consume;
  assign wdog_full = run && (wdog_q == {WDOG_WIDTH{1'b1}}) && !activity;

  assign in_ready_o        = fwd;
  assign core_data_valid_o = fwd;
  assign core_data_o       = run ? in_data_i : '0;
  assign out_valid_o       = out_valid_q;
  assign out_data_o        = out_data_q;
  assign resp_tag_o        = tag_q;
  assign resp_tag_ok_o     = tag_ok_q;
  assign resp_err_o        = err_q;
  assign core_decrypt_o    = dec_q;
  assign core_ad_size_o    = ad_size_q;
  assign core_di_size_o    = di_size_q;
  assign core_key_o        = key_q;
  assign core_nonce_o      = nonce_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Next-state and per-state handshake outputs.
  always_comb begin
    state_nx     = state;
    cmd_ready_o  = 1'b0;
    core_start_o = 1'b0;
    resp_valid_o = 1'b0;
    case (state)
      S_IDLE: begin
        // Gated by rst_n so the port reads 0 while reset is held.
        cmd_ready_o = rst_n && core_idle_i;
        if (cmd_valid_i && rst_n && core_idle_i) state_nx = S_START;
      end
      S_START: begin
        core_start_o = 1'b1;
        state_nx     = S_RUN;
      end
      S_RUN: begin
        if (core_done_i || wdog_full) state_nx = S_DRAIN;
      end
      S_DRAIN: begin
        if (!out_valid_q) state_nx = S_RESP;
      end
      S_RESP: begin
        resp_valid_o = 1'b1;
        if (resp_ready_i) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Job registers: loaded on acceptance, held until the next acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_q     <= 1'b0;
      ad_size_q <= '0;
      di_size_q <= '0;
      key_q     <= '0;
      nonce_q   <= '0;
      exp_tag_q <= '0;
    end else if (accept) begin
      dec_q     <= cmd_decrypt_i;
      ad_size_q <= cmd_ad_size_i;
      di_size_q <= cmd_di_size_i;
      key_q     <= cmd_key_i;
      nonce_q   <= cmd_nonce_i;
      exp_tag_q <= cmd_tag_i;
    end
  end

  // Tag capture, tag check and error flag for the response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_q      <= '0;
      tag_ok_q   <= 1'b0;
      err_q      <= 1'b0;
      tag_seen_q <= 1'b0;
    end else if (accept) begin
      tag_q      <= '0;
      tag_ok_q   <= 1'b0;
      err_q      <= 1'b0;
      tag_seen_q <= 1'b0;
    end else if (run) begin
      if (core_tag_valid_i) begin
        tag_q      <= core_tag_i;
        tag_ok_q   <= dec_q ? (core_tag_i == exp_tag_q) : 1'b1;
        tag_seen_q <= 1'b1;
      end
      // A done with no tag ever seen (including this cycle) is a failed job.
      if (core_done_i) begin
        if (!tag_seen_q && !core_tag_valid_i) begin
          err_q    <= 1'b1;
          tag_ok_q <= 1'b0;
        end
      end else if (wdog_full) begin
        err_q    <= 1'b1;
        tag_ok_q <= 1'b0;
      end
    end
  end

  // One-entry output register; a new capture beats a same-cycle consume.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else if (run && core_data_valid_i) begin
      out_valid_q <= 1'b1;
      out_data_q  <= core_data_i;
    end else if (consume) begin
      out_valid_q <= 1'b0;
    end
  end

  // Stall watchdog: counts idle RUN cycles, cleared by any traffic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                wdog_q <= '0;
    else if (!run || activity) wdog_q <= '0;
    else                       wdog_q <= wdog_q + 1'b1;
  end

endmodule

// File: tb/tb_ascon_job_sequencer.sv
// Directed bench for ascon_job_sequencer. A small behavioural core stands in
// for ascon_core: it XORs each DI block with key^nonce and returns as tag the
// XOR of key^nonce, the AD block and every ciphertext block.
module tb_ascon_job_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  localparam logic [127:0] KEY   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] NONCE = 128'h101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] KS    = {16{8'h10}};
  localparam logic [127:0] AD    = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] PT0   = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] PT1   = 128'hdeadbeefcafebabe0badf00d12345678;
  localparam logic [127:0] CT0   = 128'h1133557799bbddffeeccaa8866442200;
  localparam logic [127:0] CT1   = 128'hcebdaeffdaeeaaae1bbde01d02244668;
  localparam logic [127:0] TAG   = KS ^ AD ^ CT0 ^ CT1;

  int nvec = 0;
  int nerr = 0;

  // main DUT stimulus / observation
  logic         cmd_valid = 0, cmd_ready, cmd_dec = 0;
  logic [7:0]   cmd_ad = 0, cmd_di = 0;
  logic [127:0] cmd_key = 0, cmd_nonce = 0, cmd_tag = 0;
  logic         in_valid = 0, in_ready;
  logic [127:0] in_data = 0;
  logic         out_valid, out_ready = 1;
  logic [127:0] out_data;
  logic         resp_valid, resp_ready = 1, resp_ok, resp_err;
  logic [127:0] resp_tag;
  logic         c_start, c_dec, c_din_v, c_idle, c_done, c_rdy, c_dout_v, c_tag_v;
  logic [7:0]   c_ad, c_di;
  logic [127:0] c_key, c_nonce, c_din, c_dout, c_tag;

  ascon_job_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_decrypt_i(cmd_dec),
    .cmd_ad_size_i(cmd_ad), .cmd_di_size_i(cmd_di), .cmd_key_i(cmd_key),
    .cmd_nonce_i(cmd_nonce), .cmd_tag_i(cmd_tag),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
    .resp_valid_o(resp_valid), .resp_ready_i(resp_ready), .resp_tag_o(resp_tag),
    .resp_tag_ok_o(resp_ok), .resp_err_o(resp_err),
    .core_start_o(c_start), .core_decrypt_o(c_dec), .core_ad_size_o(c_ad),
    .core_di_size_o(c_di), .core_key_o(c_key), .core_nonce_o(c_nonce),
    .core_data_o(c_din), .core_data_valid_o(c_din_v),
    .core_idle_i(c_idle), .core_done_i(c_done), .core_data_ready_i(c_rdy),
    .core_data_i(c_dout), .core_data_valid_i(c_dout_v),
    .core_tag_i(c_tag), .core_tag_valid_i(c_tag_v)
  );

  // behavioural core for the main DUT
  logic         cm_busy, cm_dec;
  logic         cm_no_tag = 0;
  int           cm_ad_left, cm_di_left, cm_wait;
  logic [127:0] cm_ks, cm_acc;
  assign c_idle = !cm_busy;
  assign c_rdy  = cm_busy && cm_wait == 0 && (cm_ad_left != 0 || cm_di_left != 0);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cm_busy <= 0; cm_dec <= 0; cm_ad_left <= 0; cm_di_left <= 0; cm_wait <= 0;
      cm_ks <= '0; cm_acc <= '0;
      c_dout_v <= 0; c_dout <= '0; c_tag_v <= 0; c_tag <= '0; c_done <= 0;
    end else begin
      c_dout_v <= 0; c_tag_v <= 0; c_done <= 0;
      if (c_start) begin
        cm_busy    <= 1;
        cm_ad_left <= (int'(c_ad) + 15) / 16;
        cm_di_left <= (int'(c_di) + 15) / 16;
        cm_wait    <= 0;
        cm_ks      <= c_key ^ c_nonce;
        cm_acc     <= c_key ^ c_nonce;
        cm_dec     <= c_dec;
      end else if (cm_busy) begin
        if (c_din_v && c_rdy) begin
          cm_wait <= 2;
          if (cm_ad_left != 0) begin
            cm_ad_left <= cm_ad_left - 1;
            cm_acc     <= cm_acc ^ c_din;
          end else begin
            cm_di_left <= cm_di_left - 1;
            c_dout_v   <= 1;
            c_dout     <= c_din ^ cm_ks;
            cm_acc     <= cm_acc ^ (cm_dec ? c_din : (c_din ^ cm_ks));
          end
        end else if (cm_wait != 0) begin
          cm_wait <= cm_wait - 1;
        end else if (cm_ad_left == 0 && cm_di_left == 0) begin
          c_tag_v <= !cm_no_tag;
          c_tag   <= cm_acc;
          c_done  <= 1;
          cm_busy <= 0;
        end
      end
    end
  end

  // second DUT with a 4-bit watchdog, driven by a core that never finishes
  logic         cmd_valid_w = 0, cmd_ready_w, in_valid_w = 0, in_ready_w;
  logic         out_valid_w, resp_valid_w, resp_ok_w, resp_err_w;
  logic [127:0] out_data_w, resp_tag_w, c_key_w, c_nonce_w, c_din_w;
  logic         c_start_w, c_dec_w, c_din_v_w, c_idle_w, w_kick = 0;
  logic [7:0]   c_ad_w, c_di_w;

  ascon_job_sequencer #(.WDOG_WIDTH(4)) dut_w (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid_i(cmd_valid_w), .cmd_ready_o(cmd_ready_w), .cmd_decrypt_i(1'b0),
    .cmd_ad_size_i(8'd16), .cmd_di_size_i(8'd32), .cmd_key_i(KEY),
    .cmd_nonce_i(NONCE), .cmd_tag_i(128'h0),
    .in_valid_i(in_valid_w), .in_ready_o(in_ready_w), .in_data_i(in_data),
    .out_valid_o(out_valid_w), .out_ready_i(1'b1), .out_data_o(out_data_w),
    .resp_valid_o(resp_valid_w), .resp_ready_i(1'b1), .resp_tag_o(resp_tag_w),
    .resp_tag_ok_o(resp_ok_w), .resp_err_o(resp_err_w),
    .core_start_o(c_start_w), .core_decrypt_o(c_dec_w), .core_ad_size_o(c_ad_w),
    .core_di_size_o(c_di_w), .core_key_o(c_key_w), .core_nonce_o(c_nonce_w),
    .core_data_o(c_din_w), .core_data_valid_o(c_din_v_w),
    .core_idle_i(c_idle_w), .core_done_i(1'b0), .core_data_ready_i(!c_idle_w),
    .core_data_i(128'h0), .core_data_valid_i(1'b0),
    .core_tag_i(128'h0), .core_tag_valid_i(1'b0)
  );

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)         c_idle_w <= 1;
    else if (c_start_w) c_idle_w <= 0;
    else if (w_kick)    c_idle_w <= 1;
  end

  // monitors: inputs change just after posedge, so negedge sees settled values
  logic [127:0] out_q[$];
  int start_cnt = 0;
  int overlap   = 0;
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) out_q.push_back(out_data);
    if (c_start) start_cnt <= start_cnt + 1;
    if (resp_valid && out_valid) overlap <= overlap + 1;
  end

  logic [127:0] r_tag;
  logic         r_ok, r_err;

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic send_cmd(input logic dec, input logic [127:0] etag, output int waited);
    cmd_dec = dec; cmd_ad = 8'd16; cmd_di = 8'd32;
    cmd_key = KEY; cmd_nonce = NONCE; cmd_tag = etag; cmd_valid = 1;
    waited = 0;
    @(negedge clk);
    while (!cmd_ready && waited < 100) begin @(negedge clk); waited++; end
    nvec++;
    if (cmd_ready !== 1'b1) begin
      nerr++; $display("FAIL cmd_accept: ready=%0b, wanted 1 within 100 cycles", cmd_ready);
    end
    tick;
    cmd_valid = 0;
  endtask

  task automatic feed(input logic [127:0] d);
    int n = 0;
    in_valid = 1; in_data = d;
    @(negedge clk);
    while (!in_ready && n < 200) begin @(negedge clk); n++; end
    nvec++;
    if (in_ready !== 1'b1) begin
      nerr++; $display("FAIL in_accept: in_ready=%0b, wanted 1 within 200 cycles", in_ready);
    end
    tick;
    in_valid = 0;
  endtask

  task automatic wait_resp;
    int n = 0;
    @(negedge clk);
    while (!resp_valid && n < 300) begin @(negedge clk); n++; end
    nvec++;
    if (resp_valid !== 1'b1) begin
      nerr++; $display("FAIL resp_timeout: resp_valid=%0b, wanted 1 within 300 cycles", resp_valid);
    end
    r_tag = resp_tag; r_ok = resp_ok; r_err = resp_err;
  endtask

  task automatic run_job(input logic dec, input logic [127:0] etag,
                         input logic [127:0] d0, input logic [127:0] d1);
    int w;
    out_q.delete();
    send_cmd(dec, etag, w);
    feed(AD); feed(d0); feed(d1);
    wait_resp;
  endtask

  task automatic check_outs(input string nm, input logic [127:0] e0, input logic [127:0] e1);
    nvec++;
    if (out_q.size() != 2) begin
      nerr++; $display("FAIL %s_count: got %0d blocks, wanted 2", nm, out_q.size());
    end else begin
      if (out_q[0] !== e0) begin nerr++; $display("FAIL %s_blk0: got %h wanted %h", nm, out_q[0], e0); end
      nvec++;
      if (out_q[1] !== e1) begin nerr++; $display("FAIL %s_blk1: got %h wanted %h", nm, out_q[1], e1); end
    end
  endtask

  task automatic check_resp(input string nm, input logic [127:0] etag, input logic eok, input logic eerr);
    nvec++;
    if (r_tag !== etag) begin nerr++; $display("FAIL %s_tag: got %h wanted %h", nm, r_tag, etag); end
    nvec++;
    if (r_ok !== eok) begin nerr++; $display("FAIL %s_tag_ok: got %0b wanted %0b", nm, r_ok, eok); end
    nvec++;
    if (r_err !== eerr) begin nerr++; $display("FAIL %s_err: got %0b wanted %0b", nm, r_err, eerr); end
  endtask

  task automatic test_reset;
    rst_n = 0;
    repeat (2) @(negedge clk);
    nvec++;
    if ({cmd_ready, in_ready, out_valid, resp_valid, c_start, c_din_v, resp_ok, resp_err} !== 8'b0 ||
        out_data !== '0 || resp_tag !== '0 || c_key !== '0 || c_ad !== '0) begin
      nerr++; $display("FAIL reset_outputs: cmd_ready=%0b out_valid=%0b resp_valid=%0b, wanted all 0",
                       cmd_ready, out_valid, resp_valid);
    end
    tick; rst_n = 1;
    @(negedge clk);
    nvec++;
    if (cmd_ready !== 1'b1) begin nerr++; $display("FAIL reset_cmd_ready: got %0b wanted 1", cmd_ready); end
    tick;
  endtask

  task automatic test_encrypt;
    start_cnt = 0;
    run_job(0, 128'h0, PT0, PT1);
    check_outs("enc", CT0, CT1);
    check_resp("enc", TAG, 1'b1, 1'b0);
    nvec++;
    if (start_cnt !== 1) begin nerr++; $display("FAIL enc_start_pulse: got %0d cycles wanted 1", start_cnt); end
    nvec++;
    if ({c_dec, c_ad, c_di} !== {1'b0, 8'd16, 8'd32} || c_key !== KEY || c_nonce !== NONCE) begin
      nerr++; $display("FAIL enc_core_cfg: ad=%0d di=%0d dec=%0b, wanted 16 32 0", c_ad, c_di, c_dec);
    end
    tick;
  endtask

  task automatic test_decrypt;
    run_job(1, TAG, CT0, CT1);
    check_outs("dec", PT0, PT1);
    check_resp("dec", TAG, 1'b1, 1'b0);
    tick;
  endtask

  task automatic test_bad_tag;
    run_job(1, TAG ^ 128'h1, CT0, CT1);
    check_outs("badtag", PT0, PT1);
    check_resp("badtag", TAG, 1'b0, 1'b0);
    tick;
  endtask

  task automatic test_no_tag;
    cm_no_tag = 1;
    run_job(0, 128'h0, PT0, PT1);
    check_outs("notag", CT0, CT1);
    check_resp("notag", 128'h0, 1'b0, 1'b1);
    cm_no_tag = 0;
    tick;
  endtask

  task automatic test_backpressure;
    int w;
    int n = 0;
    int bad = 0;
    logic [127:0] held;
    overlap = 0;
    out_q.delete();
    out_ready = 0;
    send_cmd(0, 128'h0, w);
    feed(AD); feed(PT0);
    @(negedge clk);
    while (!out_valid && n < 50) begin @(negedge clk); n++; end
    held = out_data;
    nvec++;
    if (held !== CT0) begin nerr++; $display("FAIL bp_first_out: got %h wanted %h", held, CT0); end
    tick;
    in_valid = 1; in_data = PT1;
    repeat (20) begin
      @(negedge clk);
      if (in_ready !== 0 || c_din_v !== 0 || resp_valid !== 0 || out_valid !== 1 || out_data !== held) bad++;
    end
    nvec++;
    if (bad != 0) begin nerr++; $display("FAIL bp_hold: %0d bad cycles, wanted 0", bad); end
    tick;
    out_ready = 1;
    feed(PT1);
    wait_resp;
    check_outs("bp", CT0, CT1);
    check_resp("bp", TAG, 1'b1, 1'b0);
    nvec++;
    if (overlap != 0) begin nerr++; $display("FAIL bp_resp_early: %0d cycles with resp and out valid, wanted 0", overlap); end
    tick;
  endtask

  task automatic test_stall;
    int n = 0;
    int bad = 0;
    cmd_valid_w = 1;
    @(negedge clk);
    while (!cmd_ready_w && n < 50) begin @(negedge clk); n++; end
    tick; cmd_valid_w = 0;
    in_valid_w = 1; in_data = AD; n = 0;
    @(negedge clk);
    while (!in_ready_w && n < 50) begin @(negedge clk); n++; end
    tick; in_valid_w = 0;
    repeat (15) begin @(negedge clk); if (resp_valid_w !== 0) bad++; end
    nvec++;
    if (bad != 0) begin nerr++; $display("FAIL stall_early_resp: %0d early cycles, wanted 0", bad); end
    n = 0;
    while (!resp_valid_w && n < 10) begin @(negedge clk); n++; end
    nvec++;
    if (resp_valid_w !== 1) begin nerr++; $display("FAIL stall_resp: resp_valid=%0b wanted 1", resp_valid_w); end
    nvec++;
    if ({resp_err_w, resp_ok_w} !== 2'b10) begin
      nerr++; $display("FAIL stall_flags: err=%0b ok=%0b wanted err=1 ok=0", resp_err_w, resp_ok_w);
    end
    bad = 0;
    repeat (3) begin @(negedge clk); if (cmd_ready_w !== 0) bad++; end
    nvec++;
    if (bad != 0) begin nerr++; $display("FAIL stall_cmd_ready_busy: %0d cycles ready, wanted 0", bad); end
    tick; w_kick = 1;
    tick; w_kick = 0;
    @(negedge clk);
    nvec++;
    if (cmd_ready_w !== 1) begin nerr++; $display("FAIL stall_cmd_ready_idle: got %0b wanted 1", cmd_ready_w); end
    tick;
  endtask

  task automatic test_back_to_back;
    int w;
    run_job(0, 128'h0, PT0, PT1);
    check_resp("b2b1", TAG, 1'b1, 1'b0);
    tick;
    out_q.delete();
    send_cmd(1, TAG, w);
    nvec++;
    if (w != 0) begin nerr++; $display("FAIL b2b_accept: waited %0d cycles, wanted 0", w); end
    feed(AD); feed(CT0); feed(CT1);
    wait_resp;
    check_outs("b2b2", PT0, PT1);
    check_resp("b2b2", TAG, 1'b1, 1'b0);
    tick;
  endtask

  task automatic test_reset_midjob;
    int w;
    int n = 0;
    out_ready = 0;
    send_cmd(0, 128'h0, w);
    feed(AD); feed(PT0);
    @(negedge clk);
    while (!out_valid && n < 50) begin @(negedge clk); n++; end
    tick;
    rst_n = 0;
    #1;
    nvec++;
    if ({cmd_ready, in_ready, out_valid, resp_valid, c_start, c_din_v, c_dec} !== 7'b0 ||
        out_data !== '0 || c_key !== '0 || c_din !== '0) begin
      nerr++; $display("FAIL rst_mid_outputs: out_valid=%0b out_data=%h, wanted 0", out_valid, out_data);
    end
    tick; tick;
    rst_n = 1; out_ready = 1;
    tick;
    run_job(0, 128'h0, PT0, PT1);
    check_outs("postrst", CT0, CT1);
    check_resp("postrst", TAG, 1'b1, 1'b0);
    tick;
  endtask

  initial begin
    test_reset;
    test_encrypt;
    test_decrypt;
    test_bad_tag;
    test_no_tag;
    test_backpressure;
    test_stall;
    test_back_to_back;
    test_reset_midjob;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end
endmodule
